// File: rtl/datapath_seq_pkg.sv
// Shared constants for the datapath sequencer: FSM state encodings and default
// operand width and scratch register slots.
package datapath_seq_pkg;

  localparam int SIZE_DATA_DEF = 16;

  localparam logic [2:0] REG_A_DEF = 3'd0;
  localparam logic [2:0] REG_B_DEF = 3'd1;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t WR_A = 3'd1;
  localparam state_t WR_B = 3'd2;
  localparam state_t EXEC = 3'd3;
  localparam state_t DONE = 3'd4;

endpackage

// File: rtl/datapath_seq.sv
// Sequencer that runs one binary ALU operation through the register-file datapath.
// Define DATAPATH_SEQ_OPCOUNT_EN to add the op_count completed-operation counter output.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int         SIZE_DATA = SIZE_DATA_DEF,
  parameter logic [2:0] REG_A     = REG_A_DEF,
  parameter logic [2:0] REG_B     = REG_B_DEF,
  parameter int         EXEC_WAIT = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [SIZE_DATA-1:0] req_a,
  input  logic [SIZE_DATA-1:0] req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SIZE_DATA-1:0] res_data,
  output logic                 busy,
  output logic [SIZE_DATA-1:0] dp_din,
  output logic                 dp_we,
  output logic [2:0]           dp_w1,
  output logic [2:0]           dp_r1,
  output logic [2:0]           dp_r2,
  output logic [2:0]           dp_ms,
  input  logic [SIZE_DATA-1:0] dp_alu_out
`ifdef DATAPATH_SEQ_OPCOUNT_EN
  ,
  output logic [15:0]          op_count
`endif
);

  localparam int CNT_W = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;

  generate
    if (REG_A == REG_B) begin : g_bad_slots
      $error("datapath_seq: REG_A and REG_B must name different slots");
    end
    if (EXEC_WAIT < 1) begin : g_bad_wait
      $error("datapath_seq: EXEC_WAIT must be at least 1");
    end
  endgenerate

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [SIZE_DATA-1:0] a_q, a_d;
  logic [SIZE_DATA-1:0] b_q, b_d;
  logic [SIZE_DATA-1:0] res_q, res_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = WR_A;
        end
      end
      WR_A: state_d = WR_B;
      WR_B: begin
        cnt_d   = CNT_W'(EXEC_WAIT - 1);
        state_d = EXEC;
      end
      EXEC: begin
        // The ALU output is sampled only once the read addresses have settled for EXEC_WAIT cycles.
        if (cnt_q == '0) begin
          res_d   = dp_alu_out;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    dp_we  = 1'b0;
    dp_w1  = 3'd0;
    dp_din = '0;
    case (state_q)
      WR_A: begin
        dp_we  = 1'b1;
        dp_w1  = REG_A;
        dp_din = a_q;
      end
      WR_B: begin
        dp_we  = 1'b1;
        dp_w1  = REG_B;
        dp_din = b_q;
      end
      default: ;
    endcase
  end

  assign dp_r1     = REG_A;
  assign dp_r2     = REG_B;
  assign dp_ms     = op_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_q;

`ifdef DATAPATH_SEQ_OPCOUNT_EN
  logic [15:0] op_count_q, op_count_d;

  // Counts completed result handshakes and wraps naturally at 16 bits.
  always_comb begin
    op_count_d = op_count_q;
    if (res_valid && res_ready) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq with a behavioural register file/ALU model
// attached and a scoreboard of expected results keyed by accepted requests.
module tb_datapath_seq;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqOp;
  logic [15:0] reqA;
  logic [15:0] reqB;
  logic        resValid;
  logic        resReady;
  logic [15:0] resData;
  logic        busy;
  logic [15:0] dpDin;
  logic        dpWe;
  logic [2:0]  dpW1;
  logic [2:0]  dpR1;
  logic [2:0]  dpR2;
  logic [2:0]  dpMs;
  logic [15:0] dpAluOut;
`ifdef DATAPATH_SEQ_OPCOUNT_EN
  logic [15:0] opCount;
`endif

  int          nCompared = 0;
  int          nMismatched = 0;
  int          nHandshakes = 0;
  logic [15:0] sbQ[$];
  logic [15:0] rf[8];
  int          w;

  datapath_seq dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_op     (reqOp),
    .req_a      (reqA),
    .req_b      (reqB),
    .res_valid  (resValid),
    .res_ready  (resReady),
    .res_data   (resData),
    .busy       (busy),
    .dp_din     (dpDin),
    .dp_we      (dpWe),
    .dp_w1      (dpW1),
    .dp_r1      (dpR1),
    .dp_r2      (dpR2),
    .dp_ms      (dpMs),
    .dp_alu_out (dpAluOut)
`ifdef DATAPATH_SEQ_OPCOUNT_EN
    ,
    .op_count   (opCount)
`endif
  );

  always #5 CLK = ~CLK;

  // ALU behaviour of the attached datapath
  function automatic logic [15:0] aluModel(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Register file model: one write port, two combinational read ports
  always @(posedge CLK) begin
    if (dpWe) rf[dpW1] <= dpDin;
  end

  assign dpAluOut = aluModel(dpMs, rf[dpR1], rf[dpR2]);

  // Scoreboard: push on request acceptance, pop on result handshake
  always @(negedge CLK) begin
    if (RST_N) begin
      if (reqValid && reqReady) sbQ.push_back(aluModel(reqOp, reqA, reqB));
      if (dpWe) checkOutput("write_slot", 32'(dpW1 == 3'd0 || dpW1 == 3'd1), 32'd1);
      if (resValid && resReady) begin
        nHandshakes++;
        if (sbQ.size() == 0) checkOutput("unexpected_result", 32'd1, 32'd0);
        else checkOutput("result", 32'(resData), 32'(sbQ.pop_front()));
      end
    end
  end

  always @(negedge RST_N) begin
    sbQ.delete();
    nHandshakes = 0;
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               output int waitCycles);
    reqOp      = op;
    reqA       = a;
    reqB       = b;
    reqValid   = 1'b1;
    waitCycles = 0;
    @(negedge CLK);
    while (!reqReady && waitCycles < 100) begin
      @(negedge CLK);
      waitCycles++;
    end
    if (!reqReady) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1 reqValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge CLK);
    while ((!reqReady || sbQ.size() != 0) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reqValid = 1'b0;
    reqOp    = 3'd0;
    reqA     = 16'd0;
    reqB     = 16'd0;
    resReady = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 16'd0;

    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dp_we", 32'(dpWe), 32'd0);
    checkOutput("rst_res_valid", 32'(resValid), 32'd0);
    checkOutput("rst_res_data", 32'(resData), 32'd0);
    checkOutput("rst_dp_din", 32'(dpDin), 32'd0);
    checkOutput("rst_dp_r1", 32'(dpR1), 32'd0);
    checkOutput("rst_dp_r2", 32'(dpR2), 32'd1);
    checkOutput("rst_dp_ms", 32'(dpMs), 32'd0);
`ifdef DATAPATH_SEQ_OPCOUNT_EN
    checkOutput("rst_op_count", 32'(opCount), 32'd0);
`endif
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Single add with result backpressure
    resReady = 1'b0;
    applyStimulus(3'd0, 16'h0005, 16'h0003, w);
    @(negedge CLK);
    checkOutput("wra_we", 32'(dpWe), 32'd1);
    checkOutput("wra_w1", 32'(dpW1), 32'd0);
    checkOutput("wra_din", 32'(dpDin), 32'h5);
    @(negedge CLK);
    checkOutput("wrb_we", 32'(dpWe), 32'd1);
    checkOutput("wrb_w1", 32'(dpW1), 32'd1);
    checkOutput("wrb_din", 32'(dpDin), 32'h3);
    @(negedge CLK);
    checkOutput("exec_we", 32'(dpWe), 32'd0);
    checkOutput("exec_din", 32'(dpDin), 32'd0);
    checkOutput("exec_res_valid", 32'(resValid), 32'd0);
    checkOutput("exec_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    checkOutput("latency_res_valid", 32'(resValid), 32'd1);
    checkOutput("latency_res_data", 32'(resData), 32'h8);
    @(posedge CLK);
    #1;
    reqOp    = 3'd4;
    reqA     = 16'h1234;
    reqB     = 16'h4321;
    reqValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checkOutput("stall_res_valid", 32'(resValid), 32'd1);
      checkOutput("stall_res_data", 32'(resData), 32'h8);
      checkOutput("stall_req_ready", 32'(reqReady), 32'd0);
    end
    @(posedge CLK);
    #1;
    reqValid = 1'b0;
    resReady = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("release_req_ready", 32'(reqReady), 32'd1);
    checkOutput("release_res_valid", 32'(resValid), 32'd0);
    checkOutput("ignored_req_queue", 32'(sbQ.size()), 32'd0);
    @(posedge CLK);
    #1;

    // Back-to-back requests with req_valid held high
    applyStimulus(3'd0, 16'h0005, 16'h0003, w);
    applyStimulus(3'd0, 16'hFFFF, 16'h0001, w);
    checkOutput("b2b_spacing", 32'(w), 32'd4);
    waitIdle();

    // Assorted operations
    applyStimulus(3'd1, 16'h0003, 16'h0005, w);
    waitIdle();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i), 16'($urandom), 16'($urandom), w);
      waitIdle();
    end

`ifdef DATAPATH_SEQ_OPCOUNT_EN
    checkOutput("op_count", 32'(opCount), 32'(nHandshakes));
`endif

    // Reset asserted during WR_B
    applyStimulus(3'd2, 16'hF0F0, 16'h0FF0, w);
    @(posedge CLK);
    #2;
    checkOutput("midop_we_before", 32'(dpWe), 32'd1);
    RST_N = 1'b0;
    #1;
    checkOutput("midop_we_async", 32'(dpWe), 32'd0);
    checkOutput("midop_res_valid", 32'(resValid), 32'd0);
    checkOutput("midop_busy", 32'(busy), 32'd0);
    checkOutput("midop_req_ready", 32'(reqReady), 32'd1);
`ifdef DATAPATH_SEQ_OPCOUNT_EN
    checkOutput("midop_op_count", 32'(opCount), 32'd0);
`endif
    @(negedge CLK) RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("post_rst_idle", 32'(reqReady), 32'd1);
    checkOutput("post_rst_res_valid", 32'(resValid), 32'd0);
    @(posedge CLK);
    #1;
    applyStimulus(3'd1, 16'd100, 16'd1, w);
    waitIdle();
    applyStimulus(3'd3, 16'hA000, 16'h000A, w);
    waitIdle();
    applyStimulus(3'd0, 16'h7FFF, 16'h0001, w);
    waitIdle();
`ifdef DATAPATH_SEQ_OPCOUNT_EN
    checkOutput("op_count_after_rst", 32'(opCount), 32'd3);
`endif

    checkOutput("queue_empty", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
